// File: rtl/booth_multiplier_32.sv
// Pipelined 32x32 signed multiplier, 64-bit product, fixed 5-cycle latency.
// Radix-4 Booth recoding, carry-save reduction tree, final carry-propagate add.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rstn         - synchronous reset, ACTIVE-HIGH despite the name
//   multiplicand - signed operand A, sampled every rising edge
//   multiplier   - signed operand B, sampled every rising edge
//   result       - registered signed product A*B
//
// Stages: S1 operand capture, S2 Booth partial products, S3 17->4 rows,
// S4 4->2 rows, S5 final add into result.
module booth_multiplier_32 (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [63:0] result
);

  // 3:2 compressor; the carry row is pre-shifted, the bit leaving position 63
  // is dropped because the product is modulo 2^64.
  function automatic logic [63:0] csa_sum(input logic [63:0] x, input logic [63:0] y,
                                          input logic [63:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [63:0] csa_carry(input logic [63:0] x, input logic [63:0] y,
                                            input logic [63:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  // S1
  logic [31:0] a_q, b_q;

  // S2
  logic [32:0] b_ext;
  logic [63:0] a_ext;
  logic [2:0]  trip   [16];
  logic [63:0] mag    [16];
  logic [63:0] pp_d   [16];
  logic [63:0] pp_q   [16];
  logic [15:0] neg_d, neg_q;

  // S3
  logic [63:0] corr;
  logic [63:0] lvl0   [17];
  logic [63:0] lvl1   [12];
  logic [63:0] lvl2   [8];
  logic [63:0] lvl3   [6];
  logic [63:0] row_d  [4];
  logic [63:0] row_q  [4];

  // S4
  logic [63:0] t_sum, t_carry;
  logic [63:0] sum_d, carry_d, sum_q, carry_q;

  // S5
  logic [63:0] result_d;

  // Booth recoding: digit i looks at B[2i+1], B[2i], B[2i-1] with B[-1] = 0.
  // A negative digit is emitted as ~|d*A| plus a +1 at bit 2i; the inversion
  // is done before the shift so the vacated low bits stay zero.
  always_comb begin
    b_ext = {b_q, 1'b0};
    a_ext = {{32{a_q[31]}}, a_q};
    neg_d = '0;
    for (int i = 0; i < 16; i++) begin
      trip[i] = b_ext[2*i +: 3];
      mag[i]  = '0;
      case (trip[i])
        3'b001, 3'b010: mag[i] = a_ext;
        3'b011:         mag[i] = a_ext << 1;
        3'b100: begin
          mag[i]   = a_ext << 1;
          neg_d[i] = 1'b1;
        end
        3'b101, 3'b110: begin
          mag[i]   = a_ext;
          neg_d[i] = 1'b1;
        end
        default:        mag[i] = '0;
      endcase
      pp_d[i] = (neg_d[i] ? ~mag[i] : mag[i]) << (2 * i);
    end
  end

  // 17 rows (16 partial products + correction) -> 12 -> 8 -> 6 -> 4.
  always_comb begin
    corr = '0;
    for (int i = 0; i < 16; i++) begin
      corr[2*i] = neg_q[i];
    end
    for (int i = 0; i < 16; i++) begin
      lvl0[i] = pp_q[i];
    end
    lvl0[16] = corr;

    for (int j = 0; j < 5; j++) begin
      lvl1[2*j]   = csa_sum(lvl0[3*j], lvl0[3*j+1], lvl0[3*j+2]);
      lvl1[2*j+1] = csa_carry(lvl0[3*j], lvl0[3*j+1], lvl0[3*j+2]);
    end
    lvl1[10] = lvl0[15];
    lvl1[11] = lvl0[16];

    for (int j = 0; j < 4; j++) begin
      lvl2[2*j]   = csa_sum(lvl1[3*j], lvl1[3*j+1], lvl1[3*j+2]);
      lvl2[2*j+1] = csa_carry(lvl1[3*j], lvl1[3*j+1], lvl1[3*j+2]);
    end

    for (int j = 0; j < 2; j++) begin
      lvl3[2*j]   = csa_sum(lvl2[3*j], lvl2[3*j+1], lvl2[3*j+2]);
      lvl3[2*j+1] = csa_carry(lvl2[3*j], lvl2[3*j+1], lvl2[3*j+2]);
    end
    lvl3[4] = lvl2[6];
    lvl3[5] = lvl2[7];

    for (int j = 0; j < 2; j++) begin
      row_d[2*j]   = csa_sum(lvl3[3*j], lvl3[3*j+1], lvl3[3*j+2]);
      row_d[2*j+1] = csa_carry(lvl3[3*j], lvl3[3*j+1], lvl3[3*j+2]);
    end
  end

  // 4 rows -> sum/carry pair.
  always_comb begin
    t_sum   = csa_sum(row_q[0], row_q[1], row_q[2]);
    t_carry = csa_carry(row_q[0], row_q[1], row_q[2]);
    sum_d   = csa_sum(t_sum, t_carry, row_q[3]);
    carry_d = csa_carry(t_sum, t_carry, row_q[3]);
  end

  always_comb begin
    result_d = sum_q + carry_q;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= '0;
      for (int i = 0; i < 16; i++) begin
        pp_q[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        row_q[i] <= '0;
      end
      sum_q   <= '0;
      carry_q <= '0;
      result  <= '0;
    end else begin
      a_q     <= multiplicand;
      b_q     <= multiplier;
      neg_q   <= neg_d;
      for (int i = 0; i < 16; i++) begin
        pp_q[i] <= pp_d[i];
      end
      for (int i = 0; i < 4; i++) begin
        row_q[i] <= row_d[i];
      end
      sum_q   <= sum_d;
      carry_q <= carry_d;
      result  <= result_d;
    end
  end

endmodule

// File: tb/tb_booth_multiplier_32.sv
module tb_booth_multiplier_32;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [63:0] result;

  int total = 0;
  int bad   = 0;

  // Expected result after each edge: a product enters at [0] and is due at [4].
  logic [63:0] pipe [5];

  logic [31:0] dv_a [10];
  logic [31:0] dv_b [10];
  logic [63:0] dv_p [10];

  booth_multiplier_32 dut (
    .clk         (clk),
    .rstn        (rstn),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] exp);
    total++;
    assert (result === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, result, exp);
    end
  endtask

  // One clock: drive operands/reset, advance the reference on the edge, then
  // compare the registered result at the following falling edge.
  task automatic cyc(input logic [31:0] a, input logic [31:0] b, input logic r);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    multiplicand = a;
    multiplier   = b;
    rstn         = r;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 5; i++) pipe[i] = '0;
    end else begin
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
      for (int i = 4; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = ea * eb;
    end
    @(negedge clk);
    chk("stream", pipe[4]);
  endtask

  // Back-to-back directed vectors; vector i is due on the 5th cycle after it.
  task automatic run_directed(input int n);
    for (int i = 0; i < n + 4; i++) begin
      if (i < n) cyc(dv_a[i], dv_b[i], 1'b0);
      else       cyc(32'd0, 32'd0, 1'b0);
      if (i >= 4) chk($sformatf("dir%0d", i - 4), dv_p[i-4]);
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) pipe[i] = '0;
    multiplicand = '0;
    multiplier   = '0;
    rstn         = 1'b1;

    // Reset held for 5 cycles with live operands.
    for (int i = 0; i < 5; i++) begin
      cyc(32'd7, 32'd9, 1'b1);
      chk("rst_hold", 64'd0);
    end
    // Release: 7*9 shows up on the 5th cycle.
    for (int i = 0; i < 4; i++) begin
      cyc(32'd7, 32'd9, 1'b0);
      chk("rst_drain", 64'd0);
    end
    cyc(32'd7, 32'd9, 1'b0);
    chk("rst_first", 64'd63);

    dv_a[0] = 32'd3;          dv_b[0] = 32'hFFFF_FFFB; dv_p[0] = 64'hFFFF_FFFF_FFFF_FFF1;
    dv_a[1] = 32'hFFFF_FFFD;  dv_b[1] = 32'd5;         dv_p[1] = 64'hFFFF_FFFF_FFFF_FFF1;
    dv_a[2] = 32'hFFFF_FFFD;  dv_b[2] = 32'hFFFF_FFFB; dv_p[2] = 64'd15;
    dv_a[3] = 32'd0;          dv_b[3] = 32'hFFFF_FFFF; dv_p[3] = 64'd0;
    dv_a[4] = 32'h8000_0000;  dv_b[4] = 32'h8000_0000; dv_p[4] = 64'h4000_0000_0000_0000;
    dv_a[5] = 32'h8000_0000;  dv_b[5] = 32'h7FFF_FFFF; dv_p[5] = 64'hC000_0000_8000_0000;
    dv_a[6] = 32'h7FFF_FFFF;  dv_b[6] = 32'h7FFF_FFFF; dv_p[6] = 64'h3FFF_FFFF_0000_0001;
    dv_a[7] = 32'hFFFF_FFFF;  dv_b[7] = 32'hFFFF_FFFF; dv_p[7] = 64'd1;
    dv_a[8] = 32'd1;          dv_b[8] = 32'hAAAA_AAAA; dv_p[8] = 64'hFFFF_FFFF_AAAA_AAAA;
    dv_a[9] = 32'd1;          dv_b[9] = 32'h5555_5555; dv_p[9] = 64'h0000_0000_5555_5555;
    run_directed(10);

    // Random back-to-back stream.
    for (int i = 0; i < 1000; i++) begin
      cyc($urandom, $urandom, 1'b0);
    end

    // One-cycle reset in the middle of a random stream: the reset edge and
    // the four after it must all read zero.
    for (int i = 0; i < 20; i++) cyc($urandom, $urandom, 1'b0);
    cyc($urandom, $urandom, 1'b1);
    chk("mid_rst0", 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc($urandom, $urandom, 1'b0);
      chk($sformatf("mid_rst%0d", i + 1), 64'd0);
    end
    for (int i = 0; i < 30; i++) cyc($urandom, $urandom, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
